// File: rtl/multi_port_ram_arb.sv
// Multi-port scratch RAM with write-collision arbitration.
//
// A DEPTH x DATA_WIDTH array is shared by NUM_WPORTS write ports and NUM_RPORTS
// read ports. After reset the array is swept to zero, one word per clock. Requests
// are only accepted once init_done is high.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   wr_en         per-port write enable
//   wr_addr       packed write addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   wr_data       packed write data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_en         per-port read enable
//   rd_addr       packed read addresses
//   rd_data       packed registered read data; holds when no read completes
//   rd_valid      one-cycle pulse per completed read
//   wr_conflict   one-cycle pulse per write port whose write lost arbitration
//   init_done     high once the zero-fill sweep has finished
//
// Write ports that share an address are resolved by fixed priority: the lowest
// enabled index wins. RDW_MODE selects read-first (0) or write-first (1) when a
// read and the winning write hit the same address on the same edge.
// READ_LATENCY is 1 or 2.
module multi_port_ram_arb #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned NUM_WPORTS   = 4,
  parameter int unsigned NUM_RPORTS   = 4,
  parameter int unsigned RDW_MODE     = 0,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_WPORTS-1:0]            wr_en,
  input  logic [NUM_WPORTS*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WPORTS*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_RPORTS-1:0]            rd_en,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RPORTS-1:0]            rd_valid,
  output logic [NUM_WPORTS-1:0]            wr_conflict,
  output logic                             init_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   fill_cnt_q, fill_cnt_d;
  logic                    ready;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [NUM_WPORTS-1:0]   wr_win, wr_lose;
  logic [NUM_WPORTS-1:0]   wr_conflict_q;
  logic [NUM_RPORTS-1:0]   rd_accept;
  logic [DATA_WIDTH-1:0]   rd_word [NUM_RPORTS];

  logic [NUM_RPORTS-1:0]            s1_valid_q;
  logic [NUM_RPORTS*DATA_WIDTH-1:0] s1_data_q;

  assign ready     = (state_q == StReady);
  assign init_done = ready;
  assign rd_accept = rd_en & {NUM_RPORTS{ready}};

  // Zero-fill sequencer: one word per edge, READY on the edge that clears DEPTH-1.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    unique case (state_q)
      StInit: begin
        fill_cnt_d = fill_cnt_q + 1'b1;
        if (&fill_cnt_q) begin
          state_d = StReady;
        end
      end
      StReady: ;
      default: state_d = StInit;
    endcase
  end

  // Fixed-priority arbitration: a port wins unless a lower enabled port has the same address.
  always_comb begin
    wr_win  = '0;
    wr_lose = '0;
    for (int i = 0; i < NUM_WPORTS; i++) begin
      if (ready && wr_en[i]) begin
        wr_win[i] = 1'b1;
        for (int k = 0; k < i; k++) begin
          if (wr_en[k] && (wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] ==
                           wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
            wr_win[i] = 1'b0;
          end
        end
        wr_lose[i] = ~wr_win[i];
      end
    end
  end

  // Read lookup; in write-first mode the winning write on the same address bypasses the array.
  always_comb begin
    for (int j = 0; j < NUM_RPORTS; j++) begin
      rd_word[j] = mem_q[rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH]];
      if (RDW_MODE == 1) begin
        for (int i = 0; i < NUM_WPORTS; i++) begin
          if (wr_win[i] && (wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] ==
                            rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
            rd_word[j] = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  // Array is not reset; the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem_q[fill_cnt_q] <= '0;
    end else begin
      for (int i = 0; i < NUM_WPORTS; i++) begin
        if (wr_win[i]) begin
          mem_q[wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StInit;
      fill_cnt_q    <= '0;
      wr_conflict_q <= '0;
      s1_valid_q    <= '0;
      s1_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      wr_conflict_q <= wr_lose;
      s1_valid_q    <= rd_accept;
      for (int j = 0; j < NUM_RPORTS; j++) begin
        if (rd_accept[j]) begin
          s1_data_q[j*DATA_WIDTH +: DATA_WIDTH] <= rd_word[j];
        end
      end
    end
  end

  assign wr_conflict = wr_conflict_q;

  if (READ_LATENCY == 1) begin : g_lat1
    assign rd_data  = s1_data_q;
    assign rd_valid = s1_valid_q;
  end else begin : g_lat2
    logic [NUM_RPORTS-1:0]            s2_valid_q;
    logic [NUM_RPORTS*DATA_WIDTH-1:0] s2_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_q <= '0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        for (int j = 0; j < NUM_RPORTS; j++) begin
          if (s1_valid_q[j]) begin
            s2_data_q[j*DATA_WIDTH +: DATA_WIDTH] <= s1_data_q[j*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end

    assign rd_data  = s2_data_q;
    assign rd_valid = s2_valid_q;
  end

endmodule

// File: tb/tb_multi_port_ram_arb.sv
// Directed bench: dut0 is read-first / latency 1, dut1 is write-first / latency 2.
// Both share all inputs.
module tb_multi_port_ram_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  wr_en;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  rd_en;
  logic [15:0] rd_addr;

  logic [31:0] rd_data0, rd_data1;
  logic [3:0]  rd_valid0, rd_valid1;
  logic [3:0]  wr_conflict0, wr_conflict1;
  logic        init_done0, init_done1;

  int checks = 0;
  int errors = 0;

  multi_port_ram_arb #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_WPORTS(4), .NUM_RPORTS(4),
    .RDW_MODE(0), .READ_LATENCY(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .wr_conflict(wr_conflict0), .init_done(init_done0)
  );

  multi_port_ram_arb #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_WPORTS(4), .NUM_RPORTS(4),
    .RDW_MODE(1), .READ_LATENCY(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .wr_conflict(wr_conflict1), .init_done(init_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Release reset and watch the 16-edge sweep; reads stay enabled throughout.
  task automatic do_init();
    rd_en   = 4'b1111;
    rd_addr = 16'h0000;
    rst_n   = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("init_no_valid0", rd_valid0, 4'b0000);
      chk("init_no_valid1", rd_valid1, 4'b0000);
      if (i < 16) chk("init_done_low", init_done0, 1'b0);
    end
    chk("init_done0", init_done0, 1'b1);
    chk("init_done1", init_done1, 1'b1);
    rd_en = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    logic [3:0] a;
    rst_n   = 1'b0;
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_en   = '0;
    rd_addr = '0;
    tick();
    tick();

    // Reset state
    chk("rst_rd_data0", rd_data0, 32'h0);
    chk("rst_rd_data1", rd_data1, 32'h0);
    chk("rst_rd_valid0", rd_valid0, 4'b0000);
    chk("rst_rd_valid1", rd_valid1, 4'b0000);
    chk("rst_conflict0", wr_conflict0, 4'b0000);
    chk("rst_init_done0", init_done0, 1'b0);
    chk("rst_init_done1", init_done1, 1'b0);

    do_init();

    // Every address reads zero after the sweep
    rd_en = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      a = i[3:0];
      rd_addr = {a, a, a, a};
      tick();
      chk("fill_data0", rd_data0, 32'h0);
      chk("fill_valid0", rd_valid0, 4'b1111);
      chk("fill_data1", rd_data1, 32'h0);
      chk("fill_valid1", rd_valid1, (i == 0) ? 4'b0000 : 4'b1111);
    end
    rd_en = 4'b0000;
    tick();
    chk("fill_tail_valid0", rd_valid0, 4'b0000);
    chk("fill_tail_valid1", rd_valid1, 4'b1111);
    tick();

    // Collision: ports 1..3 at addr 5, port 1 wins
    wr_en   = 4'b1110;
    wr_addr = {4'd5, 4'd5, 4'd5, 4'd5};
    wr_data = {8'h44, 8'h33, 8'h22, 8'h11};
    tick();
    chk("coll_conflict0", wr_conflict0, 4'b1100);
    chk("coll_conflict1", wr_conflict1, 4'b1100);
    wr_en = 4'b0000;
    tick();
    chk("coll_conflict_clr0", wr_conflict0, 4'b0000);
    chk("coll_conflict_clr1", wr_conflict1, 4'b0000);
    rd_en   = 4'b0001;
    rd_addr = {4'd0, 4'd0, 4'd0, 4'd5};
    tick();
    chk("coll_rd0", rd_data0[7:0], 8'h22);
    chk("coll_valid0", rd_valid0, 4'b0001);
    chk("coll_valid1_early", rd_valid1, 4'b0000);
    rd_en = 4'b0000;
    tick();
    chk("coll_rd1", rd_data1[7:0], 8'h22);
    chk("coll_valid1", rd_valid1, 4'b0001);
    chk("coll_valid0_clr", rd_valid0, 4'b0000);
    chk("coll_hold0", rd_data0[7:0], 8'h22);
    tick();

    // Read-during-write at addr 3
    wr_en   = 4'b0001;
    wr_addr = {4'd0, 4'd0, 4'd0, 4'd3};
    wr_data = {24'h0, 8'hAA};
    tick();
    wr_data = {24'h0, 8'hBB};
    rd_en   = 4'b0001;
    rd_addr = {4'd0, 4'd0, 4'd0, 4'd3};
    tick();
    chk("rdw_old0", rd_data0[7:0], 8'hAA);
    wr_en = 4'b0000;
    rd_en = 4'b0000;
    tick();
    chk("rdw_new1", rd_data1[7:0], 8'hBB);
    rd_en = 4'b0001;
    tick();
    chk("rdw_follow0", rd_data0[7:0], 8'hBB);
    rd_en = 4'b0000;
    tick();
    chk("rdw_follow1", rd_data1[7:0], 8'hBB);

    // Losing write at addr 9 is never visible, even to a write-first bypass
    wr_en   = 4'b0011;
    wr_addr = {4'd0, 4'd0, 4'd9, 4'd9};
    wr_data = {16'h0, 8'hDD, 8'hCC};
    rd_en   = 4'b0001;
    rd_addr = {4'd0, 4'd0, 4'd0, 4'd9};
    tick();
    chk("lose_old0", rd_data0[7:0], 8'h00);
    chk("lose_conflict0", wr_conflict0, 4'b0010);
    wr_en = 4'b0000;
    rd_en = 4'b0000;
    tick();
    chk("lose_bypass1", rd_data1[7:0], 8'hCC);
    rd_en = 4'b0001;
    tick();
    chk("lose_stored0", rd_data0[7:0], 8'hCC);
    rd_en = 4'b0000;
    tick();
    chk("lose_stored1", rd_data1[7:0], 8'hCC);

    // Latency: preload 1..3, then stream three reads on port 2
    wr_en   = 4'b0111;
    wr_addr = {4'd0, 4'd3, 4'd2, 4'd1};
    wr_data = {8'h00, 8'h03, 8'h02, 8'h01};
    tick();
    wr_en   = 4'b0000;
    rd_en   = 4'b0100;
    rd_addr = {4'd0, 4'd1, 4'd0, 4'd0};
    tick();
    chk("lat_a1_d0", rd_data0[23:16], 8'h01);
    chk("lat_a1_v1", rd_valid1, 4'b0000);
    rd_addr = {4'd0, 4'd2, 4'd0, 4'd0};
    tick();
    chk("lat_a2_d0", rd_data0[23:16], 8'h02);
    chk("lat_a1_d1", rd_data1[23:16], 8'h01);
    chk("lat_a1_vv1", rd_valid1, 4'b0100);
    rd_addr = {4'd0, 4'd3, 4'd0, 4'd0};
    tick();
    chk("lat_a3_d0", rd_data0[23:16], 8'h03);
    chk("lat_a2_d1", rd_data1[23:16], 8'h02);
    chk("lat_a2_v1", rd_valid1, 4'b0100);
    rd_en = 4'b0000;
    tick();
    chk("lat_end_v0", rd_valid0, 4'b0000);
    chk("lat_a3_d1", rd_data1[23:16], 8'h03);
    chk("lat_a3_v1", rd_valid1, 4'b0100);
    tick();
    chk("lat_idle_v1", rd_valid1, 4'b0000);
    chk("lat_hold_d1", rd_data1[23:16], 8'h03);

    // Mid-operation reset with a latency-2 read in flight
    wr_en   = 4'b0001;
    wr_addr = {4'd0, 4'd0, 4'd0, 4'd7};
    wr_data = {24'h0, 8'h5A};
    tick();
    wr_en   = 4'b0000;
    rd_en   = 4'b0001;
    rd_addr = {4'd0, 4'd0, 4'd0, 4'd7};
    tick();
    chk("mid_pre_d0", rd_data0[7:0], 8'h5A);
    rd_en = 4'b0000;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_v1", rd_valid1, 4'b0000);
    chk("mid_rst_v0", rd_valid0, 4'b0000);
    chk("mid_rst_d1", rd_data1, 32'h0);
    chk("mid_rst_done0", init_done0, 1'b0);
    chk("mid_rst_done1", init_done1, 1'b0);
    tick();
    tick();
    chk("mid_hold_v1", rd_valid1, 4'b0000);
    do_init();
    rd_en   = 4'b0001;
    rd_addr = {4'd0, 4'd0, 4'd0, 4'd7};
    tick();
    chk("mid_clr_d0", rd_data0[7:0], 8'h00);
    chk("mid_clr_v0", rd_valid0, 4'b0001);
    rd_en = 4'b0000;
    tick();
    chk("mid_clr_d1", rd_data1[7:0], 8'h00);
    chk("mid_clr_v1", rd_valid1, 4'b0001);

    // Parallel ports: four distinct writes, four reads of addr 2
    wr_en   = 4'b1111;
    wr_addr = {4'd3, 4'd2, 4'd1, 4'd0};
    wr_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    tick();
    chk("par_conflict0", wr_conflict0, 4'b0000);
    chk("par_conflict1", wr_conflict1, 4'b0000);
    wr_en   = 4'b0000;
    rd_en   = 4'b1111;
    rd_addr = {4'd2, 4'd2, 4'd2, 4'd2};
    tick();
    chk("par_d0", rd_data0, 32'hA2A2A2A2);
    chk("par_v0", rd_valid0, 4'b1111);
    chk("par_v1_early", rd_valid1, 4'b0000);
    rd_en = 4'b0000;
    tick();
    chk("par_d1", rd_data1, 32'hA2A2A2A2);
    chk("par_v1", rd_valid1, 4'b1111);
    chk("par_v0_clr", rd_valid0, 4'b0000);
    tick();
    chk("par_v1_clr", rd_valid1, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_port_ram_arb.md
Name: multi_port_ram_arb

Overview:
- Parametrised successor to the team's flat multi-port register-file RAM, with independent write and read port counts.
- Adds deterministic write-collision arbitration with per-port conflict flags.
- Adds a selectable read-during-write mode, a 1- or 2-cycle registered read pipeline with per-port valid, and a post-reset zero-fill sequencer.
- Sits between multiple requesting engines and a shared scratch store.

Parameters:
- DATA_WIDTH, 8, bits per word.
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH.
- NUM_WPORTS, 4, number of write ports (>=1).
- NUM_RPORTS, 4, number of read ports (>=1).
- RDW_MODE, 0, read-during-write to the same address: 0 = read-first (old data), 1 = write-first (bypass winning write data).
- READ_LATENCY, 1, read pipeline depth; legal values 1 or 2 only.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  NUM_WPORTS  per-port write enable.
- wr_addr  in  NUM_WPORTS*ADDR_WIDTH  packed write addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- wr_data  in  NUM_WPORTS*DATA_WIDTH  packed write data; port i at [i*DATA_WIDTH +: DATA_WIDTH].
- rd_en  in  NUM_RPORTS  per-port read enable.
- rd_addr  in  NUM_RPORTS*ADDR_WIDTH  packed read addresses.
- rd_data  out  NUM_RPORTS*DATA_WIDTH  packed registered read data.
- rd_valid  out  NUM_RPORTS  one-cycle pulse marking new rd_data for that port.
- wr_conflict  out  NUM_WPORTS  one-cycle pulse per write port whose write was dropped.
- init_done  out  1  high once zero-fill completes; requests are accepted only while high.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_data, rd_valid, wr_conflict, init_done, all pipeline registers and the fill counter go to 0.
  - FSM goes to INIT.
  - Memory array is not reset; it is cleared by the INIT sweep.
- FSM, 2 states:
  - INIT: each rising edge writes 0 to mem[fill_cnt], then fill_cnt increments.
  - On the edge that writes address DEPTH-1, FSM moves to READY and init_done is set to 1. With DEPTH=16, init_done is first high after the 16th rising edge following rst_n release.
  - READY: terminal state; left only by reset.
  - Reset asserted mid-sweep or mid-operation: everything returns to INIT and the sweep restarts from address 0.
- Request gating: wr_en and rd_en sampled on an edge where init_done=0 are ignored. No write, no rd_valid, no wr_conflict.
- Write arbitration (READY):
  - Among enabled write ports sharing one address, the lowest index wins and only its data is written.
  - Every other enabled port at that address has its write dropped and its wr_conflict bit pulses high for exactly one cycle, registered after the sampling edge.
  - Distinct addresses all write in the same cycle.
  - wr_conflict is 0 whenever there is no collision.
- Read (READY):
  - rd_en[j] sampled at edge N.
  - READ_LATENCY=1: rd_data[j] and rd_valid[j] update after edge N.
  - READ_LATENCY=2: the same values appear after edge N+1 instead.
  - rd_valid[j] is high for exactly one cycle per accepted read. Back-to-back reads give continuous valid.
  - rd_data[j] holds its last value when no new read completes.
- Read-during-write (same edge, same address, after arbitration):
  - RDW_MODE=0: read returns the pre-write content.
  - RDW_MODE=1: read returns the winning port's wr_data.
  - A dropped (losing) write is never visible to any read.
- Multiple read ports may read the same address in the same cycle; every port receives identical data.
- Address wrap: none. Addresses are exactly ADDR_WIDTH bits and every value is legal.
- Pipeline: the latency-2 stage has no stall or backpressure. Reset flushes in-flight reads (no rd_valid after reset).

Test Plan:
- Init: release rst_n, read all 16 addresses with rd_en every cycle from the 16th edge on -> init_done rises after the 16th edge, no rd_valid before then, every read returns 0x00.
- Collision: wr_en=4'b1110, all ports at addr 5, data 0x11/0x22/0x33/0x44 on ports 0..3, then read addr 5 -> data 0x22 (port 1 wins), wr_conflict=4'b1100 for one cycle, then 0.
- Read-during-write: write 0xAA to addr 3, then simultaneously write 0xBB to addr 3 and read addr 3 -> RDW_MODE=0 returns 0xAA, RDW_MODE=1 returns 0xBB; a follow-up read returns 0xBB in both modes.
- Latency: READ_LATENCY=2, rd_en on port 2 for 3 consecutive cycles at addrs 1,2,3 preloaded 0x01/0x02/0x03 -> rd_valid[2] high on cycles N+2..N+4 with data 0x01, 0x02, 0x03; rd_data holds 0x03 afterwards.
- Mid-operation reset: pulse rst_n low while a latency-2 read is in flight after writing 0x5A to addr 7 -> rd_valid stays 0, init_done drops, after 16 edges init_done=1 and addr 7 reads 0x00.
- Parallel ports: 4 writes to distinct addresses 0..3 in one cycle, then 4 reads of addr 2 on all ports -> all four rd_data equal the value written to addr 2, rd_valid=4'b1111 for one cycle, no wr_conflict.
